// File: rtl/control_selector_frecuencia_pkg.sv
// Purpose: shared constants, types and helpers for the frequency selector.
//   - N_SEL / SEL_W : size of the frequency table and its index width
//   - CNT_W         : half-period counter width
//   - HALF_*_DEF    : default half-period lengths (clk cycles) at 100 MHz
//   - state_t       : selector FSM encoding (IDLE, PEND)
//   - make_half_tab : builds the half-period lookup table from four lengths
package control_selector_frecuencia_pkg;

    localparam int unsigned N_SEL = 4;
    localparam int unsigned CNT_W = 27;

    localparam int unsigned HALF_0_DEF = 50_000_000;
    localparam int unsigned HALF_1_DEF = 5_000_000;
    localparam int unsigned HALF_2_DEF = 500_000;
    localparam int unsigned HALF_3_DEF = 50_000;

    // Index width, never below one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned SEL_W = sel_width(N_SEL);

    typedef logic [SEL_W-1:0]            sel_t;
    typedef logic [CNT_W-1:0]            cnt_t;
    typedef logic [N_SEL-1:0][CNT_W-1:0] half_tab_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    // Half-period table; values are zero-extended into CNT_W bits.
    function automatic half_tab_t make_half_tab(input int unsigned h0,
                                                input int unsigned h1,
                                                input int unsigned h2,
                                                input int unsigned h3);
        half_tab_t t;
        t[0] = CNT_W'(h0);
        t[1] = CNT_W'(h1);
        t[2] = CNT_W'(h2);
        t[3] = CNT_W'(h3);
        return t;
    endfunction

endpackage

// File: rtl/control_selector_frecuencia_if.sv
// Purpose: user-facing signal bundle of the frequency selector.
//   - btn_up / btn_down : raw pushbutton levels, asynchronous to clk
//   - en                : divider run enable
//   - clk_out / tick    : divided square wave and its toggle pulse
//   - sel / sel_pend    : committed and requested frequency index
//   - cambio_pend       : a requested index is waiting to be committed
// master drives the buttons and enable; slave is the selector itself.
interface control_selector_frecuencia_if;
    import control_selector_frecuencia_pkg::*;

    logic btn_up;
    logic btn_down;
    logic en;
    logic clk_out;
    logic tick;
    sel_t sel;
    sel_t sel_pend;
    logic cambio_pend;

    modport master (
        output btn_up, btn_down, en,
        input  clk_out, tick, sel, sel_pend, cambio_pend
    );

    modport slave (
        input  btn_up, btn_down, en,
        output clk_out, tick, sel, sel_pend, cambio_pend
    );

endinterface

// File: rtl/control_selector_frecuencia_divisor_programable.sv
// Purpose: programmable half-period counter producing a 50 % duty square wave.
//   - clk, reset   : system clock, asynchronous active-high reset
//   - en_i         : 1 = count, 0 = counter and clk_out hold
//   - half_len_i   : half-period length in clk cycles
//   - load_zero_i  : restart the half-period from zero on this edge
//   - clk_out_o    : divided clock (registered)
//   - tick_o       : one-cycle pulse in the cycle clk_out_o toggles (registered)
//   - tc_c         : terminal count this cycle (combinational)
module control_selector_frecuencia_divisor_programable
    import control_selector_frecuencia_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  cnt_t half_len_i,
    input  logic load_zero_i,
    output logic clk_out_o,
    output logic tick_o,
    output logic tc_c
);

    cnt_t cnt_q;
    cnt_t cnt_d;
    logic clk_out_q;
    logic clk_out_d;
    logic tick_q;
    logic tick_d;

    // Last cycle of the current half-period.
    assign tc_c = en_i && (cnt_q == (half_len_i - CNT_W'(1)));

    // Counter advance, wrap and toggle.
    always_comb begin
        cnt_d     = cnt_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        if (en_i) begin
            if (tc_c) begin
                cnt_d     = '0;
                clk_out_d = ~clk_out_q;
                tick_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // A commit while paused restarts the half-period but keeps the level.
        if (load_zero_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/control_selector_frecuencia.sv
// Purpose: pushbutton-driven frequency selector for the programmable divider.
// A requested index is only committed at a half-period boundary (or while the
// divider is paused), so clk_out never produces a short or long half-period.
//   - clk, reset : system clock, asynchronous active-high reset
//   - bus        : slave side of control_selector_frecuencia_if
//                  (btn_up, btn_down, en in; clk_out, tick, sel, sel_pend,
//                  cambio_pend out)
module control_selector_frecuencia
    import control_selector_frecuencia_pkg::*;
#(
    parameter int unsigned HALF_0 = HALF_0_DEF,
    parameter int unsigned HALF_1 = HALF_1_DEF,
    parameter int unsigned HALF_2 = HALF_2_DEF,
    parameter int unsigned HALF_3 = HALF_3_DEF
)(
    input  logic                          clk,
    input  logic                          reset,
    control_selector_frecuencia_if.slave  bus
);

    localparam half_tab_t HALF_TAB = make_half_tab(HALF_0, HALF_1, HALF_2, HALF_3);
    localparam sel_t      SEL_MAX  = SEL_W'(N_SEL - 1);

    // Bit 0 = up button, bit 1 = down button.
    logic [1:0] btn_s1_q;
    logic [1:0] btn_s2_q;
    logic [1:0] btn_prev_q;
    logic [1:0] pulse_c;
    logic       up_c;
    logic       down_c;

    state_t state_q;
    state_t state_d;
    sel_t   sel_q;
    sel_t   sel_d;
    sel_t   sel_pend_q;
    sel_t   sel_pend_d;
    sel_t   req_c;
    logic   cambio_pend_q;
    logic   commit_c;
    logic   tc_c;
    cnt_t   half_len_c;

    // Two-flop synchronizer followed by a rising-edge detect flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            btn_prev_q <= '0;
        end else begin
            btn_s1_q   <= {bus.btn_down, bus.btn_up};
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
        end
    end

    assign pulse_c = btn_s2_q & ~btn_prev_q;
    // Simultaneous up and down cancel each other.
    assign up_c    = pulse_c[0] & ~pulse_c[1];
    assign down_c  = pulse_c[1] & ~pulse_c[0];

    assign half_len_c = HALF_TAB[sel_q];

    // Request saturation and commit FSM.
    always_comb begin
        req_c      = sel_pend_q;
        state_d    = state_q;
        sel_d      = sel_q;
        sel_pend_d = sel_pend_q;
        commit_c   = 1'b0;

        if (up_c && (sel_pend_q != SEL_MAX)) begin
            req_c = sel_pend_q + SEL_W'(1);
        end else if (down_c && (sel_pend_q != '0)) begin
            req_c = sel_pend_q - SEL_W'(1);
        end
        sel_pend_d = req_c;

        case (state_q)
            IDLE: begin
                if (req_c != sel_q) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (tc_c || !bus.en) begin
                    // Commit the value held before this cycle's request; a
                    // request arriving now remains pending.
                    commit_c = 1'b1;
                    sel_d    = sel_pend_q;
                    state_d  = (req_c != sel_pend_q) ? PEND : IDLE;
                end else if (req_c == sel_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            sel_pend_q    <= '0;
            cambio_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            sel_pend_q    <= sel_pend_d;
            cambio_pend_q <= (state_d == PEND);
        end
    end

    control_selector_frecuencia_divisor_programable u_divisor_programable (
        .clk         (clk),
        .reset       (reset),
        .en_i        (bus.en),
        .half_len_i  (half_len_c),
        .load_zero_i (commit_c),
        .clk_out_o   (bus.clk_out),
        .tick_o      (bus.tick),
        .tc_c        (tc_c)
    );

    assign bus.sel         = sel_q;
    assign bus.sel_pend    = sel_pend_q;
    assign bus.cambio_pend = cambio_pend_q;

endmodule

// File: tb/tb_control_selector_frecuencia.sv
// Purpose: self-checking bench for control_selector_frecuencia with short
// half-periods (4, 3, 2, 1 cycles). Directed scenarios followed by random
// button/enable/reset traffic checked against a cycle-level reference model.
module tb_control_selector_frecuencia;
    import control_selector_frecuencia_pkg::*;

    localparam int unsigned H0 = 4;
    localparam int unsigned H1 = 3;
    localparam int unsigned H2 = 2;
    localparam int unsigned H3 = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    int half_tab [4] = '{int'(H0), int'(H1), int'(H2), int'(H3)};

    // Reference model state
    logic       m_clk;
    logic       m_tick;
    int         m_sel;
    int         m_pend;
    int         m_cnt;
    logic [2:0] up_h;
    logic [2:0] dn_h;

    control_selector_frecuencia_if bus ();

    control_selector_frecuencia #(
        .HALF_0 (H0),
        .HALF_1 (H1),
        .HALF_2 (H2),
        .HALF_3 (H3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] dut_vec();
        return {bus.clk_out, bus.tick, bus.sel, bus.sel_pend, bus.cambio_pend};
    endfunction

    function automatic logic [6:0] mdl_vec();
        return {m_clk, m_tick, 2'(m_sel), 2'(m_pend), (m_pend != m_sel)};
    endfunction

    task automatic model_clear();
        m_clk  = 1'b0;
        m_tick = 1'b0;
        m_sel  = 0;
        m_pend = 0;
        m_cnt  = 0;
        up_h   = '0;
        dn_h   = '0;
    endtask

    // One rising clock edge of the reference: a button press is seen three
    // edges after the level rises; the divider wraps after HALF[sel] cycles;
    // a pending index is adopted at a wrap or whenever the divider is paused.
    task automatic model_edge();
        logic pu;
        logic pd;
        logic tc;
        int   np;
        if (reset) begin
            model_clear();
            return;
        end
        pu   = up_h[1] & ~up_h[2];
        pd   = dn_h[1] & ~dn_h[2];
        up_h = {up_h[1:0], bus.btn_up};
        dn_h = {dn_h[1:0], bus.btn_down};
        tc     = bus.en && (m_cnt == half_tab[m_sel] - 1);
        m_tick = tc;
        if (tc) begin
            m_clk = ~m_clk;
            m_cnt = 0;
        end else if (bus.en) begin
            m_cnt = m_cnt + 1;
        end
        np = m_pend;
        if (pu && !pd) np = (m_pend < 3) ? m_pend + 1 : 3;
        if (pd && !pu) np = (m_pend > 0) ? m_pend - 1 : 0;
        if ((m_pend != m_sel) && (tc || !bus.en)) begin
            m_sel = m_pend;
            m_cnt = 0;
        end
        m_pend = np;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        cyc = cyc + 1;
        #1;
    endtask

    task automatic apply_reset();
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        bus.en       = 1'b1;
        reset        = 1'b1;
        model_clear();
        cycle();
        cycle();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_reset();
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        bus.en       = 1'b1;
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        n_tests++;
        if (dut_vec() !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_async: got %b expected %b", dut_vec(), 7'b0);
        end
        repeat (3) cycle();
        n_tests++;
        if (dut_vec() !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got %b expected %b", dut_vec(), 7'b0);
        end
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_cadence();
        logic [3:0] exp;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            exp = {1'((i / 4) % 2), (i % 4 == 0), 2'd0};
            n_tests++;
            if ({bus.clk_out, bus.tick, bus.sel} !== exp) begin
                n_fail++;
                $display("FAIL cadence_sel0 cycle %0d: got %b expected %b", i,
                         {bus.clk_out, bus.tick, bus.sel}, exp);
            end
        end
    endtask

    task automatic test_up_commit();
        int n;
        bus.btn_up = 1'b1;
        cycle();
        cycle();
        n_tests++;
        if (bus.sel_pend !== 2'd0) begin
            n_fail++;
            $display("FAIL up_latency: got sel_pend %0d expected 0", bus.sel_pend);
        end
        cycle();
        n_tests++;
        if ({bus.sel, bus.sel_pend, bus.cambio_pend} !== {2'd0, 2'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL up_pending: got %b expected %b",
                     {bus.sel, bus.sel_pend, bus.cambio_pend}, {2'd0, 2'd1, 1'b1});
        end
        bus.btn_up = 1'b0;
        cycle();
        n_tests++;
        if ({bus.tick, bus.sel, bus.cambio_pend} !== {1'b1, 2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL up_commit: got %b expected %b",
                     {bus.tick, bus.sel, bus.cambio_pend}, {1'b1, 2'd1, 1'b0});
        end
        for (int h = 0; h < 3; h++) begin
            n = 0;
            do begin
                cycle();
                n++;
            end while (!bus.tick && n < 10);
            n_tests++;
            if (n != 3) begin
                n_fail++;
                $display("FAIL half_len_sel1: got %0d cycles expected 3", n);
            end
        end
        n_tests++;
        if (dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL up_model: got %b expected %b", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_saturation();
        logic prev;
        apply_reset();
        for (int p = 0; p < 4; p++) begin
            bus.btn_up = 1'b1;
            cycle();
            cycle();
            bus.btn_up = 1'b0;
            cycle();
            cycle();
        end
        repeat (10) cycle();
        n_tests++;
        if ({bus.sel, bus.sel_pend, bus.cambio_pend} !== {2'd3, 2'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL sat_commit: got %b expected %b",
                     {bus.sel, bus.sel_pend, bus.cambio_pend}, {2'd3, 2'd3, 1'b0});
        end
        for (int i = 0; i < 4; i++) begin
            prev = bus.clk_out;
            cycle();
            n_tests++;
            if ({bus.tick, bus.clk_out} !== {1'b1, ~prev}) begin
                n_fail++;
                $display("FAIL half_len_sel3: got %b expected %b",
                         {bus.tick, bus.clk_out}, {1'b1, ~prev});
            end
        end
        bus.btn_up = 1'b1;
        cycle();
        cycle();
        bus.btn_up = 1'b0;
        repeat (4) cycle();
        n_tests++;
        if ({bus.sel_pend, bus.cambio_pend} !== {2'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL sat_hold: got %b expected %b",
                     {bus.sel_pend, bus.cambio_pend}, {2'd3, 1'b0});
        end
    endtask

    task automatic test_cancel();
        int n;
        apply_reset();
        for (int p = 0; p < 2; p++) begin
            bus.btn_up = 1'b1;
            cycle();
            cycle();
            bus.btn_up = 1'b0;
            cycle();
            cycle();
        end
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(bus.tick && bus.sel == 2'd2) && n < 40);
        n_tests++;
        if (n >= 40) begin
            n_fail++;
            $display("FAIL cancel_setup: got sel %0d expected 2 within 40 cycles", bus.sel);
        end
        cycle();
        bus.btn_down = 1'b1;
        cycle();
        bus.btn_up = 1'b1;
        cycle();
        cycle();
        n_tests++;
        if ({bus.tick, bus.sel, bus.sel_pend, bus.cambio_pend} !== {1'b1, 2'd2, 2'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL cancel_down: got %b expected %b",
                     {bus.tick, bus.sel, bus.sel_pend, bus.cambio_pend}, {1'b1, 2'd2, 2'd1, 1'b1});
        end
        bus.btn_down = 1'b0;
        bus.btn_up   = 1'b0;
        cycle();
        n_tests++;
        if ({bus.tick, bus.sel, bus.sel_pend, bus.cambio_pend} !== {1'b0, 2'd2, 2'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL cancel_up: got %b expected %b",
                     {bus.tick, bus.sel, bus.sel_pend, bus.cambio_pend}, {1'b0, 2'd2, 2'd2, 1'b0});
        end
        cycle();
        n_tests++;
        if ({bus.tick, bus.sel} !== {1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL cancel_cadence: got %b expected %b", {bus.tick, bus.sel}, {1'b1, 2'd2});
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        cycle();
        bus.btn_up   = 1'b1;
        bus.btn_down = 1'b1;
        repeat (6) cycle();
        n_tests++;
        if ({bus.sel_pend, bus.cambio_pend} !== {2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL simul_ignored: got %b expected %b",
                     {bus.sel_pend, bus.cambio_pend}, {2'd0, 1'b0});
        end
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        repeat (4) cycle();
        bus.btn_up = 1'b1;
        repeat (20) cycle();
        bus.btn_up = 1'b0;
        repeat (3) cycle();
        n_tests++;
        if (bus.sel_pend !== 2'd1) begin
            n_fail++;
            $display("FAIL hold_one_step: got sel_pend %0d expected 1", bus.sel_pend);
        end
    endtask

    task automatic test_reset_mid_pend();
        logic [3:0] exp;
        apply_reset();
        repeat (4) cycle();
        bus.btn_up = 1'b1;
        repeat (3) cycle();
        n_tests++;
        if ({bus.clk_out, bus.cambio_pend, bus.sel_pend, bus.sel} !== {1'b1, 1'b1, 2'd1, 2'd0}) begin
            n_fail++;
            $display("FAIL pend_before_reset: got %b expected %b",
                     {bus.clk_out, bus.cambio_pend, bus.sel_pend, bus.sel}, {1'b1, 1'b1, 2'd1, 2'd0});
        end
        reset = 1'b1;
        model_clear();
        #1;
        n_tests++;
        if (dut_vec() !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_mid_pend: got %b expected %b", dut_vec(), 7'b0);
        end
        bus.btn_up = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        cyc   = 0;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            exp = {(i == 4), (i == 4), 2'd0};
            n_tests++;
            if ({bus.tick, bus.clk_out, bus.sel} !== exp) begin
                n_fail++;
                $display("FAIL restart_cadence cycle %0d: got %b expected %b", i,
                         {bus.tick, bus.clk_out, bus.sel}, exp);
            end
        end
    endtask

    task automatic test_en_pause();
        apply_reset();
        bus.btn_up = 1'b1;
        repeat (3) cycle();
        n_tests++;
        if ({bus.cambio_pend, bus.sel} !== {1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL en_pend: got %b expected %b", {bus.cambio_pend, bus.sel}, {1'b1, 2'd0});
        end
        bus.btn_up = 1'b0;
        bus.en     = 1'b0;
        cycle();
        n_tests++;
        if ({bus.clk_out, bus.tick, bus.sel, bus.cambio_pend} !== {1'b0, 1'b0, 2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL en_commit: got %b expected %b",
                     {bus.clk_out, bus.tick, bus.sel, bus.cambio_pend}, {1'b0, 1'b0, 2'd1, 1'b0});
        end
        repeat (5) cycle();
        n_tests++;
        if ({bus.clk_out, bus.tick} !== 2'b00) begin
            n_fail++;
            $display("FAIL en_hold: got %b expected %b", {bus.clk_out, bus.tick}, 2'b00);
        end
        bus.en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            n_tests++;
            if ({bus.tick, bus.clk_out} !== {(i == 3), (i == 3)}) begin
                n_fail++;
                $display("FAIL en_resume cycle %0d: got %b expected %b", i,
                         {bus.tick, bus.clk_out}, {(i == 3), (i == 3)});
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) bus.btn_up = ~bus.btn_up;
            if ($urandom_range(0, 3) == 0) bus.btn_down = ~bus.btn_down;
            if ($urandom_range(0, 15) == 0) bus.en = ~bus.en;
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                model_clear();
                #1;
                n_tests++;
                if (dut_vec() !== 7'b0) begin
                    n_fail++;
                    $display("FAIL rand_async_reset step %0d: got %b expected %b", i, dut_vec(), 7'b0);
                end
            end
            cycle();
            n_tests++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL rand_cycle step %0d: got %b expected %b", i, dut_vec(), mdl_vec());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_cadence();
        test_up_commit();
        test_saturation();
        test_cancel();
        test_simultaneous();
        test_reset_mid_pend();
        test_en_pause();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
